pueo_trig_src_array: RTL and testbench
======================================

Name: pueo_trig_src_array

Overview:
- Parametrised, single-clock (sysclk) array of NCHAN independent timed trigger sources.
- Each channel takes an external or PPS-type input and runs edge detection, prescaling, offset address computation and holdoff deadtime.
- Each channel emits a phase-aligned {address, metadata, valid} trigger word toward the TURF trigger merger.
- Configuration arrives already synchronised to sysclk from the register block.

Parameters:
NCHAN, 4, number of trigger channels
ADDR_BITS, 12, width of cur_addr_i and output addresses
CFG_BITS, 16, width of per-channel offset/prescale/holdoff fields
PHASE_LEN, 8, sysclk cycles per sysclk_phase_i period
CAPTURE_PHASE, 2, phase count at which a pending trigger is launched
HOLD_CYCLES, 4, cycles valid_o and data are held (must be < PHASE_LEN)
DROP_BITS, 16, width of per-channel saturating drop counter

Ports:
sysclk_i  in  1  system clock
rst_n_i  in  1  asynchronous active-low reset
sysclk_phase_i  in  1  one-cycle phase marker, period PHASE_LEN
running_i  in  1  run active; low forces all channels idle
cur_addr_i  in  ADDR_BITS  current system address
trig_in_i  in  NCHAN  asynchronous trigger inputs
en_i  in  NCHAN  per-channel enable
edge_pol_i  in  NCHAN  0 = rising, 1 = falling edge
offset_i  in  NCHAN*CFG_BITS  address offset subtracted from cur_addr_i
prescale_i  in  NCHAN*CFG_BITS  accept 1 of every (prescale+1) qualified edges
prescale_update_i  in  NCHAN  pulse: reload that channel's prescale counter
holdoff_i  in  NCHAN*CFG_BITS  deadtime cycles after each launched trigger
trig_addr_o  out  NCHAN*ADDR_BITS  launched trigger address
metadata_o  out  NCHAN*8  bit7 = 1, [6:0] = per-channel trigger sequence
valid_o  out  NCHAN  trigger word valid
busy_o  out  NCHAN  channel not IDLE
drop_count_o  out  NCHAN*DROP_BITS  saturating count of rejected edges

Behaviour:
- Reset (rst_n_i low, async):
  - all FSMs IDLE; valid_o = 0, busy_o = 0.
  - trig_addr_o = 0, metadata_o = 8'h80, drop_count_o = 0.
  - prescale counters = 0; phase counter = 0; sync flops = 0.
- Phase counter: cleared to 0 on the cycle after sysclk_phase_i is sampled high; otherwise increments, wrapping PHASE_LEN-1 -> 0. Capture strobe = (phase counter == CAPTURE_PHASE).
- Input path:
  - trig_in_i passes through a 2-flop synchroniser (s1, s2); s3 holds the previous s2.
  - edge = (s2 & !s3) if edge_pol = 0, else (!s2 & s3).
  - qualified = edge & en_i & running_i.
- Per-channel FSM, states IDLE, PENDING, WRITE, HOLDOFF:
  - IDLE, qualified edge, prescale counter == 0: accept; counter <= prescale_i; trig_addr_o <= (cur_addr_i - offset_i[ADDR_BITS-1:0]) mod 2^ADDR_BITS, using cur_addr_i in the edge cycle; -> PENDING.
  - IDLE, qualified edge, prescale counter != 0: counter decrements; stay IDLE; not a drop.
  - PENDING: on capture strobe -> WRITE. Acceptance in the same cycle as the strobe does not launch; the channel waits for the next strobe.
  - WRITE: valid_o = 1 for exactly HOLD_CYCLES cycles, starting the cycle after the strobe. trig_addr_o is stable throughout.
  - Leaving WRITE: valid_o falls; metadata[6:0] increments, wrapping 127 -> 0; bit7 stays 1.
  - HOLDOFF: counter loaded with holdoff_i and counts down; -> IDLE when it reaches 0. holdoff_i = 0 returns to IDLE in one cycle.
- Drops: a qualified edge while not IDLE increments drop_count_o, saturating at all-ones. The prescale counter is unchanged.
- prescale_update_i: reloads the counter from prescale_i. If it coincides with a qualified edge in IDLE, the update wins; the edge is ignored and not counted as a drop.
- running_i low (synchronous, priority over everything except reset):
  - FSM -> IDLE; valid_o = 0 on the next cycle.
  - metadata_o = 8'h80; drop_count_o = 0; prescale counters reload from prescale_i.
  - trig_addr_o holds its value.
- busy_o = 1 in PENDING, WRITE or HOLDOFF.
- Channels are fully independent; simultaneous events on different channels do not interact.
- Config inputs are treated as static while a channel is busy. Changing offset_i, edge_pol_i or holdoff_i mid-operation affects only later acceptances or loads.

Test Plan:
- Ch0 rising, prescale 0, offset 5, holdoff 0; cur_addr 100 in the edge cycle -> addr 95 (0x05F). valid_o high 4 cycles starting the cycle after phase count 2. metadata 0x80 during the write, 0x81 after.
- Prescale 2, six edges spaced 40 cycles -> exactly 2 launches (edges 3 and 6), metadata ends 0x82, drop_count 0. prescale_update_i pulse after edge 4 -> next launch on edge 7.
- Holdoff 50, edges every 10 cycles, 6 edges -> launches on edges 1 and 6 at most; drop_count equals the edges seen while busy (expect 4). Saturation: DROP_BITS=4 with 20 drops -> 0xF.
- edge_pol 1: rising edge -> no launch; falling edge -> launch. en_i = 0 -> no launch and no drop.
- Wrap: cur_addr 3, offset 10 -> addr 0xFF9. Offset 0x1005 uses low 12 bits -> 3 - 5 = 0xFFE.
- running_i low in the 2nd WRITE cycle -> valid_o 0 next cycle, metadata 0x80, busy_o 0. rst_n_i low mid-PENDING -> all outputs at reset values immediately; the channel relaunches correctly after release.

Source files
------------

// File: rtl/pueo_trig_src_array.sv
// Array of independent timed trigger sources. Each channel detects an input edge,
// prescales it, computes an offset address and launches a phase-aligned trigger word.
module pueo_trig_src_array #(
    parameter int unsigned NCHAN         = 4,
    parameter int unsigned ADDR_BITS     = 12,
    parameter int unsigned CFG_BITS      = 16,
    parameter int unsigned PHASE_LEN     = 8,
    parameter int unsigned CAPTURE_PHASE = 2,
    parameter int unsigned HOLD_CYCLES   = 4,
    parameter int unsigned DROP_BITS     = 16
) (
    input  logic                          sysclk_i,
    input  logic                          rst_n_i,
    input  logic                          sysclk_phase_i,
    input  logic                          running_i,
    input  logic [ADDR_BITS-1:0]          cur_addr_i,
    input  logic [NCHAN-1:0]              trig_in_i,
    input  logic [NCHAN-1:0]              en_i,
    input  logic [NCHAN-1:0]              edge_pol_i,
    input  logic [NCHAN*CFG_BITS-1:0]     offset_i,
    input  logic [NCHAN*CFG_BITS-1:0]     prescale_i,
    input  logic [NCHAN-1:0]              prescale_update_i,
    input  logic [NCHAN*CFG_BITS-1:0]     holdoff_i,
    output logic [NCHAN*ADDR_BITS-1:0]    trig_addr_o,
    output logic [NCHAN*8-1:0]            metadata_o,
    output logic [NCHAN-1:0]              valid_o,
    output logic [NCHAN-1:0]              busy_o,
    output logic [NCHAN*DROP_BITS-1:0]    drop_count_o
);

    localparam int unsigned PH_W  = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
    localparam int unsigned SEQ_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_WRITE   = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_t;

    logic [PH_W-1:0]  r_phase;
    logic             w_strobe;
    logic [NCHAN-1:0] r_s1, r_s2, r_s3;
    logic [NCHAN-1:0] w_edge, w_qual;

    // Phase counter realigned by the phase marker
    always_ff @(posedge sysclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_phase <= '0;
        end else if (sysclk_phase_i) begin
            r_phase <= '0;
        end else if (r_phase == PH_W'(PHASE_LEN - 1)) begin
            r_phase <= '0;
        end else begin
            r_phase <= r_phase + PH_W'(1);
        end
    end

    assign w_strobe = (r_phase == PH_W'(CAPTURE_PHASE));

    always_ff @(posedge sysclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else begin
            r_s1 <= trig_in_i;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_edge = (r_s2 & ~r_s3 & ~edge_pol_i) | (~r_s2 & r_s3 & edge_pol_i);
    assign w_qual = w_edge & en_i & {NCHAN{running_i}};

    for (genvar c = 0; c < NCHAN; c++) begin : g_ch
        state_t               r_state, w_state_nxt;
        logic [CFG_BITS-1:0]  r_cnt, w_cnt_nxt;
        logic [CFG_BITS-1:0]  r_psc, w_psc_nxt;
        logic [ADDR_BITS-1:0] r_addr, w_addr_nxt;
        logic [SEQ_W-1:0]     r_seq, w_seq_nxt;
        logic                 r_valid, w_valid_nxt;
        logic                 r_busy;
        logic [DROP_BITS-1:0] r_drop, w_drop_nxt;
        logic [CFG_BITS-1:0]  w_offset, w_prescale, w_holdoff;

        assign w_offset   = offset_i[c*CFG_BITS +: CFG_BITS];
        assign w_prescale = prescale_i[c*CFG_BITS +: CFG_BITS];
        assign w_holdoff  = holdoff_i[c*CFG_BITS +: CFG_BITS];

        always_ff @(posedge sysclk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_psc   <= '0;
                r_addr  <= '0;
                r_seq   <= '0;
                r_valid <= 1'b0;
                r_busy  <= 1'b0;
                r_drop  <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_psc   <= w_psc_nxt;
                r_addr  <= w_addr_nxt;
                r_seq   <= w_seq_nxt;
                r_valid <= w_valid_nxt;
                r_busy  <= (w_state_nxt != ST_IDLE);
                r_drop  <= w_drop_nxt;
            end
        end

        // Next-state: run-stop dominates; prescale update wins over an edge in IDLE
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_psc_nxt   = r_psc;
            w_addr_nxt  = r_addr;
            w_seq_nxt   = r_seq;
            w_valid_nxt = r_valid;
            w_drop_nxt  = r_drop;

            if (!running_i) begin
                w_state_nxt = ST_IDLE;
                w_valid_nxt = 1'b0;
                w_seq_nxt   = '0;
                w_drop_nxt  = '0;
                w_psc_nxt   = w_prescale;
            end else begin
                if (w_qual[c] && (r_state != ST_IDLE) && (r_drop != {DROP_BITS{1'b1}})) begin
                    w_drop_nxt = r_drop + DROP_BITS'(1);
                end
                if (prescale_update_i[c]) begin
                    w_psc_nxt = w_prescale;
                end
                unique case (r_state)
                    ST_IDLE: begin
                        if (w_qual[c] && !prescale_update_i[c]) begin
                            if (r_psc == '0) begin
                                w_psc_nxt   = w_prescale;
                                w_addr_nxt  = cur_addr_i - ADDR_BITS'(w_offset);
                                w_state_nxt = ST_PENDING;
                            end else begin
                                w_psc_nxt = r_psc - CFG_BITS'(1);
                            end
                        end
                    end
                    ST_PENDING: begin
                        if (w_strobe) begin
                            w_state_nxt = ST_WRITE;
                            w_valid_nxt = 1'b1;
                            w_cnt_nxt   = CFG_BITS'(HOLD_CYCLES - 1);
                        end
                    end
                    ST_WRITE: begin
                        if (r_cnt == '0) begin
                            w_state_nxt = ST_HOLDOFF;
                            w_valid_nxt = 1'b0;
                            w_seq_nxt   = r_seq + SEQ_W'(1);
                            w_cnt_nxt   = w_holdoff;
                        end else begin
                            w_cnt_nxt = r_cnt - CFG_BITS'(1);
                        end
                    end
                    ST_HOLDOFF: begin
                        if (r_cnt == '0) begin
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_cnt_nxt = r_cnt - CFG_BITS'(1);
                        end
                    end
                    default: w_state_nxt = ST_IDLE;
                endcase
            end
        end

        assign trig_addr_o[c*ADDR_BITS +: ADDR_BITS]  = r_addr;
        assign metadata_o[c*8 +: 8]                    = {1'b1, r_seq};
        assign valid_o[c]                              = r_valid;
        assign busy_o[c]                               = r_busy;
        assign drop_count_o[c*DROP_BITS +: DROP_BITS]  = r_drop;
    end

endmodule

// File: tb/tb_pueo_trig_src_array.sv
// Directed bench for pueo_trig_src_array: launch timing, prescale, holdoff/drops,
// edge polarity, address wrap, run-stop and reset recovery.
module tb_pueo_trig_src_array;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        phase;
    logic        running;
    logic [11:0] cur_addr;
    logic [3:0]  trig, en, pol, psc_upd;
    logic [63:0] offset, prescale, holdoff;
    logic [47:0] addr;
    logic [31:0] meta;
    logic [3:0]  valid, busy;
    logic [63:0] drop;

    logic        trig2;
    logic [15:0] holdoff2;
    logic [11:0] addr2;
    logic [7:0]  meta2;
    logic        valid2, busy2;
    logic [3:0]  drop2;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    int w_cnt, w_first, w_last;
    logic [7:0] w_meta;
    int launches;
    bit ok;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // Marker high in cycles with cyc%8==0: strobe in cyc%8==3, valid in cyc%8==4..7
    assign phase = (cyc % 8) == 0;

    pueo_trig_src_array u_dut (
        .sysclk_i(clk), .rst_n_i(rst_n), .sysclk_phase_i(phase), .running_i(running),
        .cur_addr_i(cur_addr), .trig_in_i(trig), .en_i(en), .edge_pol_i(pol),
        .offset_i(offset), .prescale_i(prescale), .prescale_update_i(psc_upd),
        .holdoff_i(holdoff), .trig_addr_o(addr), .metadata_o(meta), .valid_o(valid),
        .busy_o(busy), .drop_count_o(drop)
    );

    pueo_trig_src_array #(.NCHAN(1), .DROP_BITS(4)) u_dut4 (
        .sysclk_i(clk), .rst_n_i(rst_n), .sysclk_phase_i(phase), .running_i(running),
        .cur_addr_i(cur_addr), .trig_in_i(trig2), .en_i(1'b1), .edge_pol_i(1'b0),
        .offset_i(16'd0), .prescale_i(16'd0), .prescale_update_i(1'b0),
        .holdoff_i(holdoff2), .trig_addr_o(addr2), .metadata_o(meta2), .valid_o(valid2),
        .busy_o(busy2), .drop_count_o(drop2)
    );

    task automatic watch_clear();
        w_cnt = 0; w_first = -1; w_last = -1; w_meta = 8'h00;
    endtask

    // Drive a level onto one trigger input and record valid activity for n cycles
    task automatic drive_watch(input int c, input logic level, input int n);
        trig[c] = level;
        repeat (n) begin
            @(negedge clk);
            if (valid[c]) begin
                if (w_cnt == 0) begin
                    w_first = cyc;
                    w_meta  = meta[c*8 +: 8];
                end
                w_last = cyc;
                w_cnt++;
            end
        end
    endtask

    task automatic run_cycle();
        running = 1'b0;
        repeat (2) @(negedge clk);
        running = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; running = 1'b0; cur_addr = '0; trig = '0; en = '0; pol = '0;
        psc_upd = '0; offset = '0; prescale = '0; holdoff = '0; trig2 = 1'b0; holdoff2 = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (valid !== 4'h0) begin n_errors++; $display("FAIL reset_valid got %h exp 0", valid); end
        n_checks++; if (busy !== 4'h0) begin n_errors++; $display("FAIL reset_busy got %h exp 0", busy); end
        n_checks++; if (addr !== 48'h0) begin n_errors++; $display("FAIL reset_addr got %h exp 0", addr); end
        n_checks++; if (meta !== 32'h80808080) begin n_errors++; $display("FAIL reset_meta got %h exp 80808080", meta); end
        n_checks++; if (drop !== 64'h0) begin n_errors++; $display("FAIL reset_drop got %h exp 0", drop); end
        n_checks++; if ({addr2, meta2, valid2, busy2, drop2} !== {12'h0, 8'h80, 1'b0, 1'b0, 4'h0}) begin
            n_errors++; $display("FAIL reset_dut4 got %h/%h/%b/%b/%h", addr2, meta2, valid2, busy2, drop2);
        end
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        run_cycle();
    endtask

    task automatic test_basic();
        cur_addr = 12'd100; offset[15:0] = 16'd5; en[0] = 1'b1;
        run_cycle();
        watch_clear();
        drive_watch(0, 1'b1, 10);
        drive_watch(0, 1'b0, 20);
        n_checks++; if (addr[11:0] !== 12'h05F) begin n_errors++; $display("FAIL basic_addr got %h exp 05f", addr[11:0]); end
        n_checks++; if (w_cnt !== 4) begin n_errors++; $display("FAIL basic_valid_len got %0d exp 4", w_cnt); end
        n_checks++; if ((w_first % 8) !== 4) begin n_errors++; $display("FAIL basic_valid_phase got %0d exp 4", w_first % 8); end
        n_checks++; if ((w_last - w_first) !== 3) begin n_errors++; $display("FAIL basic_valid_span got %0d exp 3", w_last - w_first); end
        n_checks++; if (w_meta !== 8'h80) begin n_errors++; $display("FAIL basic_meta_write got %h exp 80", w_meta); end
        n_checks++; if (meta[7:0] !== 8'h81) begin n_errors++; $display("FAIL basic_meta_after got %h exp 81", meta[7:0]); end
    endtask

    task automatic test_prescale();
        prescale[31:16] = 16'd2; en[1] = 1'b1;
        run_cycle();
        for (int e = 1; e <= 6; e++) begin
            watch_clear();
            drive_watch(1, 1'b1, 20);
            drive_watch(1, 1'b0, 20);
            n_checks++; if (w_cnt !== ((e % 3 == 0) ? 4 : 0)) begin
                n_errors++; $display("FAIL prescale_edge%0d got %0d exp %0d", e, w_cnt, (e % 3 == 0) ? 4 : 0);
            end
        end
        n_checks++; if (meta[15:8] !== 8'h82) begin n_errors++; $display("FAIL prescale_meta got %h exp 82", meta[15:8]); end
        n_checks++; if (drop[31:16] !== 16'h0) begin n_errors++; $display("FAIL prescale_drop got %h exp 0", drop[31:16]); end
        run_cycle();
        for (int e = 1; e <= 7; e++) begin
            if (e == 5) begin
                psc_upd[1] = 1'b1;
                @(negedge clk);
                psc_upd[1] = 1'b0;
            end
            watch_clear();
            drive_watch(1, 1'b1, 20);
            drive_watch(1, 1'b0, 20);
            if (e >= 5) begin
                n_checks++; if (w_cnt !== ((e == 7) ? 4 : 0)) begin
                    n_errors++; $display("FAIL update_edge%0d got %0d exp %0d", e, w_cnt, (e == 7) ? 4 : 0);
                end
            end
        end
        n_checks++; if (meta[15:8] !== 8'h82) begin n_errors++; $display("FAIL update_meta got %h exp 82", meta[15:8]); end
    endtask

    task automatic test_holdoff();
        holdoff[47:32] = 16'd50; en[2] = 1'b1;
        run_cycle();
        watch_clear();
        for (int e = 0; e < 5; e++) begin
            drive_watch(2, 1'b1, 5);
            drive_watch(2, 1'b0, 5);
        end
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = !busy[2];
        end
        n_checks++; if (!ok) begin n_errors++; $display("FAIL holdoff_idle_wait got busy exp idle"); end
        drive_watch(2, 1'b1, 5);
        drive_watch(2, 1'b0, 30);
        n_checks++; if (w_cnt !== 8) begin n_errors++; $display("FAIL holdoff_valid_cycles got %0d exp 8", w_cnt); end
        n_checks++; if (drop[47:32] !== 16'd4) begin n_errors++; $display("FAIL holdoff_drops got %0d exp 4", drop[47:32]); end
        n_checks++; if (meta[23:16] !== 8'h82) begin n_errors++; $display("FAIL holdoff_meta got %h exp 82", meta[23:16]); end
    endtask

    task automatic test_saturate();
        holdoff2 = 16'd200;
        for (int e = 0; e < 21; e++) begin
            trig2 = 1'b1; repeat (2) @(negedge clk);
            trig2 = 1'b0; repeat (2) @(negedge clk);
        end
        n_checks++; if (drop2 !== 4'hF) begin n_errors++; $display("FAIL drop_saturate got %h exp f", drop2); end
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            ok = !busy2;
        end
        n_checks++; if (!ok) begin n_errors++; $display("FAIL saturate_idle_wait got busy exp idle"); end
    endtask

    task automatic test_edge_pol();
        pol[3] = 1'b1; en[3] = 1'b1;
        watch_clear();
        drive_watch(3, 1'b1, 30);
        n_checks++; if (w_cnt !== 0) begin n_errors++; $display("FAIL pol_rise_ignored got %0d exp 0", w_cnt); end
        n_checks++; if (busy[3] !== 1'b0) begin n_errors++; $display("FAIL pol_rise_busy got %b exp 0", busy[3]); end
        watch_clear();
        drive_watch(3, 1'b0, 30);
        n_checks++; if (w_cnt !== 4) begin n_errors++; $display("FAIL pol_fall_launch got %0d exp 4", w_cnt); end
        en[3] = 1'b0;
        watch_clear();
        drive_watch(3, 1'b1, 30);
        drive_watch(3, 1'b0, 30);
        n_checks++; if (w_cnt !== 0) begin n_errors++; $display("FAIL disabled_launch got %0d exp 0", w_cnt); end
        n_checks++; if (drop[63:48] !== 16'h0) begin n_errors++; $display("FAIL disabled_drop got %h exp 0", drop[63:48]); end
    endtask

    task automatic test_wrap();
        cur_addr = 12'd3; offset[15:0] = 16'd10;
        watch_clear();
        drive_watch(0, 1'b1, 5);
        drive_watch(0, 1'b0, 30);
        n_checks++; if (addr[11:0] !== 12'hFF9) begin n_errors++; $display("FAIL wrap_addr got %h exp ff9", addr[11:0]); end
        offset[15:0] = 16'h1005;
        watch_clear();
        drive_watch(0, 1'b1, 5);
        drive_watch(0, 1'b0, 30);
        n_checks++; if (addr[11:0] !== 12'hFFE) begin n_errors++; $display("FAIL wrap_offset_trunc got %h exp ffe", addr[11:0]); end
        n_checks++; if (w_cnt !== 4) begin n_errors++; $display("FAIL wrap_valid_len got %0d exp 4", w_cnt); end
    endtask

    task automatic test_running_abort();
        cur_addr = 12'd7; offset[15:0] = 16'd0;
        trig[0] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = valid[0];
        end
        n_checks++; if (!ok) begin n_errors++; $display("FAIL abort_launch_wait got 0 exp 1"); end
        @(negedge clk);
        running = 1'b0;
        @(negedge clk);
        n_checks++; if (valid !== 4'h0) begin n_errors++; $display("FAIL abort_valid got %h exp 0", valid); end
        n_checks++; if (busy !== 4'h0) begin n_errors++; $display("FAIL abort_busy got %h exp 0", busy); end
        n_checks++; if (meta !== 32'h80808080) begin n_errors++; $display("FAIL abort_meta got %h exp 80808080", meta); end
        n_checks++; if (drop !== 64'h0) begin n_errors++; $display("FAIL abort_drop got %h exp 0", drop); end
        n_checks++; if (addr[11:0] !== 12'h007) begin n_errors++; $display("FAIL abort_addr_hold got %h exp 007", addr[11:0]); end
        trig[0] = 1'b0;
        running = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        cur_addr = 12'd20;
        trig[0] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = busy[0] && !valid[0];
        end
        n_checks++; if (!ok) begin n_errors++; $display("FAIL mid_pending_wait got 0 exp 1"); end
        rst_n = 1'b0;
        trig[0] = 1'b0;
        #1;
        n_checks++; if ({valid, busy} !== 8'h00) begin n_errors++; $display("FAIL mid_reset_vb got %h exp 00", {valid, busy}); end
        n_checks++; if (addr !== 48'h0) begin n_errors++; $display("FAIL mid_reset_addr got %h exp 0", addr); end
        n_checks++; if (meta !== 32'h80808080) begin n_errors++; $display("FAIL mid_reset_meta got %h exp 80808080", meta); end
        n_checks++; if (drop !== 64'h0) begin n_errors++; $display("FAIL mid_reset_drop got %h exp 0", drop); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        watch_clear();
        drive_watch(0, 1'b1, 5);
        drive_watch(0, 1'b0, 30);
        n_checks++; if (w_cnt !== 4) begin n_errors++; $display("FAIL relaunch_valid_len got %0d exp 4", w_cnt); end
        n_checks++; if (addr[11:0] !== 12'h014) begin n_errors++; $display("FAIL relaunch_addr got %h exp 014", addr[11:0]); end
        n_checks++; if (meta[7:0] !== 8'h81) begin n_errors++; $display("FAIL relaunch_meta got %h exp 81", meta[7:0]); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_prescale();
        test_holdoff();
        test_saturate();
        test_edge_pol();
        test_wrap();
        test_running_abort();
        test_reset_mid();
        launches = n_checks;
        $display("CHECKS %0d ERRORS %0d", launches, n_errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
